spi_master_00: RTL and testbench

SPI_MASTER_00 -- requirements
Module: spi_master_00

---
 rtl/spi_master_00.sv | 159 +++++++++++++++
 tb/tb_spi_master_00.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_00.sv
// SPI mode-0 master, LSB first, one byte per transfer.
// SCLK half-period is CLKS_PER_HALF_BIT cycles of P_CLK; all outputs are registered.
module spi_master_00 #(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       P_CLK,
  input  logic       reset,
  input  logic [7:0] i_TX_DATA,
  input  logic       i_TX_DV,
  output logic       o_TX_READY,
  output logic [7:0] o_RX_DATA,
  output logic       o_RX_DV,
  output logic       o_SCLK,
  output logic       o_MOSI,
  input  logic       i_MISO,
  output logic       o_SS
);

  localparam int HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam logic [HW-1:0] HALF_MAX = HW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t        state_reg, state_next;
  logic [HW-1:0] half_cnt_reg, half_cnt_next;
  logic [4:0]    edge_cnt_reg, edge_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          rx_dv_reg, rx_dv_next;
  logic          sclk_reg, sclk_next;
  logic          mosi_reg, mosi_next;
  logic          ss_reg, ss_next;
  logic          ready_reg, ready_next;

  logic       half_done;
  logic       last_fall;
  logic [2:0] bit_inc;

  assign half_done = (half_cnt_reg == HALF_MAX);
  // The 16th SCLK edge is the falling edge taken while 15 edges are already done.
  assign last_fall = sclk_reg && (edge_cnt_reg == 5'd15);
  assign bit_inc   = bit_idx_reg + 3'd1;

  always_ff @(posedge P_CLK or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      tx_data_reg  <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_dv_reg    <= 1'b0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      ss_reg       <= 1'b1;
      ready_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      half_cnt_reg <= half_cnt_next;
      edge_cnt_reg <= edge_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      tx_data_reg  <= tx_data_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_dv_reg    <= rx_dv_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      ss_reg       <= ss_next;
      ready_reg    <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_TX_DV)                state_next = SETUP;
      SETUP:   if (half_done)              state_next = XFER;
      XFER:    if (half_done && last_fall) state_next = HOLD;
      HOLD:    if (half_done)              state_next = GAP;
      GAP:     if (half_done)              state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  always_comb begin
    half_cnt_next = '0;
    edge_cnt_next = edge_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    tx_data_next  = tx_data_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_dv_next    = 1'b0;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    ss_next       = ss_reg;
    ready_next    = ready_reg;

    if (state_reg != IDLE && !half_done)
      half_cnt_next = half_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (i_TX_DV) begin
          tx_data_next  = i_TX_DATA;
          mosi_next     = i_TX_DATA[0];
          ss_next       = 1'b0;
          ready_next    = 1'b0;
          edge_cnt_next = '0;
          bit_idx_next  = '0;
          rx_shift_next = '0;
        end
      end
      SETUP: begin
        if (half_done) begin
          sclk_next     = 1'b1;
          edge_cnt_next = 5'd1;
          rx_shift_next = {i_MISO, rx_shift_reg[7:1]};
        end
      end
      XFER: begin
        if (half_done) begin
          sclk_next     = ~sclk_reg;
          edge_cnt_next = edge_cnt_reg + 5'd1;
          if (!sclk_reg) begin
            rx_shift_next = {i_MISO, rx_shift_reg[7:1]};
          end else if (!last_fall) begin
            bit_idx_next = bit_inc;
            mosi_next    = tx_data_reg[bit_inc];
          end
        end
      end
      HOLD: begin
        if (half_done) begin
          ss_next      = 1'b1;
          rx_data_next = rx_shift_reg;
          rx_dv_next   = 1'b1;
        end
      end
      GAP: begin
        if (half_done) begin
          ready_next = 1'b1;
          mosi_next  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_TX_READY = ready_reg;
  assign o_RX_DATA  = rx_data_reg;
  assign o_RX_DV    = rx_dv_reg;
  assign o_SCLK     = sclk_reg;
  assign o_MOSI     = mosi_reg;
  assign o_SS       = ss_reg;

endmodule

// File: tb/tb_spi_master_00.sv
// Bench for spi_master_00: one instance at H=2 and one at H=1, driven by
// a vector table plus hand-written back-to-back and abort sequences.
module tb_spi_master_00;

  logic P_CLK = 1'b0;
  logic clk_en = 1'b0;
  always #5 P_CLK = clk_en ? ~P_CLK : 1'b0;

  logic       rst2, tx_dv2, ready2, rx_dv2, sclk2, mosi2, miso2, ss2;
  logic [7:0] tx_data2, rx_data2;
  logic       rst1, tx_dv1, ready1, rx_dv1, sclk1, mosi1, miso1, ss1;
  logic [7:0] tx_data1, rx_data1;

  spi_master_00 #(.CLKS_PER_HALF_BIT(2)) dut2 (
    .P_CLK(P_CLK), .reset(rst2), .i_TX_DATA(tx_data2), .i_TX_DV(tx_dv2),
    .o_TX_READY(ready2), .o_RX_DATA(rx_data2), .o_RX_DV(rx_dv2),
    .o_SCLK(sclk2), .o_MOSI(mosi2), .i_MISO(miso2), .o_SS(ss2));

  spi_master_00 #(.CLKS_PER_HALF_BIT(1)) dut1 (
    .P_CLK(P_CLK), .reset(rst1), .i_TX_DATA(tx_data1), .i_TX_DV(tx_dv1),
    .o_TX_READY(ready1), .o_RX_DATA(rx_data1), .o_RX_DV(rx_dv1),
    .o_SCLK(sclk1), .o_MOSI(mosi1), .i_MISO(miso1), .o_SS(ss1));

  // sel picks which instance the slave model and the checks watch (0: H=2, 1: H=1)
  logic       sel = 1'b0;
  logic       lb = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  logic       slv_miso = 1'b0;
  logic [7:0] slv_cap = 8'h00;
  logic [2:0] slv_bit = 3'd0;
  int         slv_rises = 0;
  logic       ss_prev = 1'b1;
  logic       sclk_prev = 1'b0;

  logic       mon_ss, mon_sclk, mon_mosi, mon_ready, mon_rx_dv;
  logic [7:0] mon_rx_data;
  assign mon_ss      = sel ? ss1 : ss2;
  assign mon_sclk    = sel ? sclk1 : sclk2;
  assign mon_mosi    = sel ? mosi1 : mosi2;
  assign mon_ready   = sel ? ready1 : ready2;
  assign mon_rx_dv   = sel ? rx_dv1 : rx_dv2;
  assign mon_rx_data = sel ? rx_data1 : rx_data2;
  assign miso2 = lb ? mosi2 : (sel ? 1'b0 : slv_miso);
  assign miso1 = lb ? mosi1 : (sel ? slv_miso : 1'b0);

  // Mode-0 slave: presents bit0 when selected, advances on SCLK fall, captures on SCLK rise.
  always @(negedge P_CLK) begin
    if (ss_prev && !mon_ss) begin
      slv_bit   <= 3'd1;
      slv_cap   <= 8'h00;
      slv_rises <= 0;
      slv_miso  <= slv_byte[0];
    end else if (!mon_ss) begin
      if (!sclk_prev && mon_sclk) begin
        slv_cap   <= {mon_mosi, slv_cap[7:1]};
        slv_rises <= slv_rises + 1;
      end
      if (sclk_prev && !mon_sclk) begin
        slv_miso <= slv_byte[slv_bit];
        slv_bit  <= slv_bit + 3'd1;
      end
    end
    ss_prev   <= mon_ss;
    sclk_prev <= mon_sclk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel) begin
      tx_dv1 = v; tx_data1 = d;
    end else begin
      tx_dv2 = v; tx_data2 = d;
    end
  endtask

  // Requests a byte now (caller is away from a rising edge), follows it to ready.
  task automatic run_xfer(input int h, input logic [7:0] tx, input int busy_edge,
                          input logic [7:0] busy_data, input logic [7:0] exp_rx,
                          input logic [7:0] exp_cap, input string tag);
    int dv_cnt, dv_edge, rdy_edge, extra;
    logic [7:0] rx_at;
    dv_cnt = 0; dv_edge = -1; rdy_edge = -1; extra = 0; rx_at = 8'h00;
    drive(1'b1, tx);
    @(posedge P_CLK); #1;
    check({tag, " ss@0"}, 32'(mon_ss), 32'd0);
    check({tag, " ready@0"}, 32'(mon_ready), 32'd0);
    check({tag, " mosi@0"}, 32'(mon_mosi), 32'(tx[0]));
    for (int k = 1; k <= 40 * h; k++) begin
      @(negedge P_CLK);
      if (k == busy_edge) drive(1'b1, busy_data);
      else drive(1'b0, ~tx);
      @(posedge P_CLK); #1;
      if (mon_rx_dv) begin
        dv_cnt++; dv_edge = k; rx_at = mon_rx_data;
      end
      if (mon_ready) begin
        rdy_edge = k;
        break;
      end
    end
    check({tag, " rx_dv edge"}, 32'(dv_edge), 32'(17 * h));
    check({tag, " ready edge"}, 32'(rdy_edge), 32'(18 * h));
    check({tag, " rx_dv count"}, 32'(dv_cnt), 32'd1);
    check({tag, " rx_data"}, 32'(rx_at), 32'(exp_rx));
    check({tag, " slave capture"}, 32'(slv_cap), 32'(exp_cap));
    check({tag, " sclk rises"}, 32'(slv_rises), 32'd8);
    check({tag, " idle mosi"}, 32'(mon_mosi), 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(posedge P_CLK); #1;
      if (mon_rx_dv || !mon_ss) extra++;
    end
    check({tag, " quiet after"}, 32'(extra), 32'd0);
    check({tag, " rx_data held"}, 32'(mon_rx_data), 32'(exp_rx));
    $display("xfer %s: tx=%02h rx=%02h slave_cap=%02h rx_dv@%0d ready@%0d",
             tag, tx, rx_at, slv_cap, dv_edge, rdy_edge);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    logic       lb;
    int         busy_edge;
    logic [7:0] busy_data;
    logic [7:0] exp_rx;
    logic [7:0] exp_cap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int np, ss_hi, ok;
    int pe[2];
    logic [7:0] pd[2];

    vecs[0] = '{8'hA5, 8'h00, 1'b1, 0,  8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{8'h81, 8'h3C, 1'b0, 0,  8'h00, 8'h3C, 8'h81};
    vecs[2] = '{8'h55, 8'hAA, 1'b0, 10, 8'hFF, 8'hAA, 8'h55};
    vecs[3] = '{8'h00, 8'hFF, 1'b0, 0,  8'h00, 8'hFF, 8'h00};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 0,  8'h00, 8'h00, 8'hFF};
    vecs[5] = '{8'h6E, 8'h91, 1'b0, 0,  8'h00, 8'h91, 8'h6E};

    rst1 = 1'b0; rst2 = 1'b0;
    tx_dv1 = 1'b0; tx_dv2 = 1'b0; tx_data1 = 8'h00; tx_data2 = 8'h00;

    // Reset with the clock stopped
    #1 rst1 = 1'b1; rst2 = 1'b1;
    #2;
    check("rst2 ss", 32'(ss2), 32'd1);
    check("rst2 sclk", 32'(sclk2), 32'd0);
    check("rst2 mosi", 32'(mosi2), 32'd0);
    check("rst2 ready", 32'(ready2), 32'd1);
    check("rst2 rx_data", 32'(rx_data2), 32'h00);
    check("rst2 rx_dv", 32'(rx_dv2), 32'd0);
    check("rst1 ss", 32'(ss1), 32'd1);
    check("rst1 sclk", 32'(sclk1), 32'd0);
    check("rst1 ready", 32'(ready1), 32'd1);
    check("rst1 rx_data", 32'(rx_data1), 32'h00);
    $display("reset: ss=%b sclk=%b mosi=%b ready=%b rx=%02h", ss2, sclk2, mosi2, ready2, rx_data2);

    clk_en = 1'b1;
    repeat (2) @(posedge P_CLK);
    @(negedge P_CLK);
    rst1 = 1'b0; rst2 = 1'b0;

    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lb = vecs[i].lb;
      slv_byte = vecs[i].slv;
      run_xfer(2, vecs[i].tx, vecs[i].busy_edge, vecs[i].busy_data,
               vecs[i].exp_rx, vecs[i].exp_cap, $sformatf("vec%0d", i));
    end

    // Back-to-back with i_TX_DV held high, loopback
    lb = 1'b1;
    np = 0; ss_hi = 0; pe[0] = -1; pe[1] = -1; pd[0] = 8'h00; pd[1] = 8'h00;
    drive(1'b1, 8'h01);
    @(posedge P_CLK); #1;
    @(negedge P_CLK);
    drive(1'b1, 8'h02);
    for (int k = 1; k <= 200; k++) begin
      @(posedge P_CLK); #1;
      if (rx_dv2) begin
        pe[np] = k; pd[np] = rx_data2; np++;
      end
      if (np == 2) break;
      if (np == 1 && ss2) ss_hi++;
    end
    @(negedge P_CLK);
    drive(1'b0, 8'h00);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge P_CLK); #1;
      if (ready2) begin ok = 1; break; end
    end
    check("b2b pulses", 32'(np), 32'd2);
    check("b2b first edge", 32'(pe[0]), 32'd34);
    check("b2b second edge", 32'(pe[1]), 32'd71);
    check("b2b first data", 32'(pd[0]), 32'h01);
    check("b2b second data", 32'(pd[1]), 32'h02);
    check("b2b ss high cycles", 32'(ss_hi), 32'd3);
    check("b2b final ready", 32'(ok), 32'd1);
    $display("b2b: pulses@%0d,%0d data=%02h,%02h ss_high=%0d", pe[0], pe[1], pd[0], pd[1], ss_hi);

    // Abort at edge 7 on the H=1 instance, then a clean transfer
    sel = 1'b1; lb = 1'b0; slv_byte = 8'h5A;
    @(negedge P_CLK);
    drive(1'b1, 8'hF0);
    @(posedge P_CLK); #1;
    @(negedge P_CLK);
    drive(1'b0, 8'h00);
    repeat (6) @(posedge P_CLK);
    #1 check("abort busy@6", 32'(ss1), 32'd0);
    @(posedge P_CLK); #1;
    rst1 = 1'b1;
    #1;
    check("abort ss", 32'(ss1), 32'd1);
    check("abort sclk", 32'(sclk1), 32'd0);
    check("abort ready", 32'(ready1), 32'd1);
    ok = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge P_CLK); #1;
      if (rx_dv1 || sclk1) ok++;
    end
    check("abort quiet", 32'(ok), 32'd0);
    $display("abort: ss=%b sclk=%b rx_dv=%b", ss1, sclk1, rx_dv1);
    @(negedge P_CLK);
    rst1 = 1'b0;
    run_xfer(1, 8'hC3, 0, 8'h00, 8'h5A, 8'hC3, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
